// File: rtl/jvm_pkg.sv
// rtl/jvm_pkg.sv - shared JVM opcode constants and decoder state encoding
package jvm_pkg;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_ICONST_0    = 8'h03;
    localparam logic [7:0] OP_ICONST_1    = 8'h04;
    localparam logic [7:0] OP_BIPUSH      = 8'h10;
    localparam logic [7:0] OP_SIPUSH      = 8'h11;
    localparam logic [7:0] OP_LDC         = 8'h12;
    localparam logic [7:0] OP_IADD        = 8'h60;
    localparam logic [7:0] OP_IINC        = 8'h84;
    localparam logic [7:0] OP_GOTO        = 8'ha7;
    localparam logic [7:0] OP_RET         = 8'ha9;
    localparam logic [7:0] OP_TABLESWITCH = 8'haa;
    localparam logic [7:0] OP_NEWARRAY    = 8'hbc;

    typedef enum logic [1:0] {
        ST_OPC  = 2'd0,
        ST_OP1  = 2'd1,
        ST_OP2  = 2'd2,
        ST_EMIT = 2'd3
    } dec_state_e;

    function automatic logic [1:0] instr_len(input logic [1:0] cnt);
        return cnt + 2'd1;
    endfunction

endpackage

// File: rtl/bc_len_table.sv
// rtl/bc_len_table.sv - combinational operand-count and illegal-opcode lookup
module bc_len_table
    import jvm_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] count,
    output logic       illegal
);

    always_comb begin
        count   = 2'd0;
        illegal = 1'b0;
        // Illegal opcodes (variable-length switches, wide, goto_w/jsr_w, ...) decode as 1 byte
        if (opcode >= 8'hca ||
            opcode inside {OP_TABLESWITCH, 8'hab, 8'hb9, 8'hba, 8'hc4, 8'hc5, 8'hc8, 8'hc9}) begin
            illegal = 1'b1;
        end else if (opcode inside {OP_BIPUSH, OP_LDC, [8'h15:8'h19], [8'h36:8'h3a],
                                    OP_RET, OP_NEWARRAY}) begin
            count = 2'd1;
        end else if (opcode inside {OP_SIPUSH, 8'h13, 8'h14, OP_IINC, [8'h99:OP_GOTO], 8'ha8,
                                    [8'hb2:8'hb8], 8'hbb, 8'hbd, 8'hc0, 8'hc1, 8'hc6, 8'hc7}) begin
            count = 2'd2;
        end
    end

endmodule

// File: rtl/bytecode_decode.sv
// rtl/bytecode_decode.sv - byte-stream JVM instruction assembler with ready/valid handshakes
module bytecode_decode
    import jvm_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [7:0]  in_instr,
    input  logic [11:0] in_pc,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_opcode,
    output logic [15:0] out_operand,
    output logic [1:0]  out_len,
    output logic [11:0] out_pc,
    output logic        out_illegal
);

    dec_state_e  state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [15:0] operand_q, operand_d;
    logic [1:0]  len_q, len_d;
    logic [11:0] pc_q, pc_d;
    logic        illegal_q, illegal_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [1:0]  tbl_count;
    logic        tbl_illegal;
    logic        accept;

    bc_len_table u_len_table (
        .opcode  (in_instr),
        .count   (tbl_count),
        .illegal (tbl_illegal)
    );

    // In EMIT a new byte may only enter when the held instruction leaves this cycle
    assign in_ready  = !flush && ((state_q != ST_EMIT) || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_EMIT);

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        len_d     = len_q;
        pc_d      = pc_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;

        if (flush) begin
            state_d = ST_OPC;
        end else begin
            if ((state_q == ST_OPC || state_q == ST_EMIT) && accept) begin
                opcode_d  = in_instr;
                pc_d      = in_pc;
                operand_d = 16'h0000;
                cnt_d     = tbl_count;
                illegal_d = tbl_illegal;
                len_d     = instr_len(tbl_count);
                state_d   = (tbl_count == 2'd0) ? ST_EMIT : ST_OP1;
            end else begin
                case (state_q)
                    ST_OP1: begin
                        if (accept) begin
                            if (cnt_q == 2'd2) begin
                                operand_d[15:8] = in_instr;
                                state_d         = ST_OP2;
                            end else begin
                                operand_d[7:0] = in_instr;
                                state_d        = ST_EMIT;
                            end
                        end
                    end
                    ST_OP2: begin
                        if (accept) begin
                            operand_d[7:0] = in_instr;
                            state_d        = ST_EMIT;
                        end
                    end
                    ST_EMIT: begin
                        if (out_ready) begin
                            state_d = ST_OPC;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_OPC;
            opcode_q  <= 8'h00;
            operand_q <= 16'h0000;
            len_q     <= 2'd1;
            pc_q      <= 12'h000;
            illegal_q <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            len_q     <= len_d;
            pc_q      <= pc_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_opcode  = opcode_q;
    assign out_operand = operand_q;
    assign out_len     = len_q;
    assign out_pc      = pc_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_bytecode_decode.sv
// tb/tb_bytecode_decode.sv - scoreboard bench for bytecode_decode
module tb_bytecode_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [7:0]  in_instr = 8'h00;
    logic [11:0] in_pc = 12'h000;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_opcode;
    logic [15:0] out_operand;
    logic [1:0]  out_len;
    logic [11:0] out_pc;
    logic        out_illegal;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [1:0]  len;
        logic [11:0] pc;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   pop_cyc[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    bytecode_decode dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_operand (out_operand),
        .out_len     (out_len),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] op, input logic [15:0] opnd,
                                input logic [1:0] len, input logic [11:0] pc, input logic ill);
        exp_t e;
        e.op = op; e.opnd = opnd; e.len = len; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the byte is accepted
    task automatic send(input logic [7:0] b, input logic [11:0] pc);
        logic acc;
        in_valid = 1'b1;
        in_instr = b;
        in_pc    = pc;
        for (int i = 0; i < 20; i++) begin
            #1 acc = in_ready;
            @(negedge clk);
            if (acc) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: byte 0x%0h never accepted", b);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (out_valid && out_ready) begin
                pop_cyc.push_back(cyc);
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_emit: got op=0x%0h pc=0x%0h expected no instruction",
                             out_opcode, out_pc);
                end else begin
                    e = sb.pop_front();
                    if (out_opcode !== e.op || out_operand !== e.opnd || out_len !== e.len ||
                        out_pc !== e.pc || out_illegal !== e.ill) begin
                        n_fail++;
                        $display("FAIL emit_pc%0h: got op=%h opnd=%h len=%0d pc=%h ill=%b expected op=%h opnd=%h len=%0d pc=%h ill=%b",
                                 e.pc, out_opcode, out_operand, out_len, out_pc, out_illegal,
                                 e.op, e.opnd, e.len, e.pc, e.ill);
                    end
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_opcode", {24'd0, out_opcode}, 32'h00);
        check("rst_operand", {16'd0, out_operand}, 32'h0000);
        check("rst_len", {30'd0, out_len}, 32'd1);
        check("rst_pc", {20'd0, out_pc}, 32'h000);
        check("rst_illegal", {31'd0, out_illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back single-byte instructions, one per cycle
        pop_cyc.delete();
        sb.push_back(mk(8'h03, 16'h0000, 2'd1, 12'd0, 1'b0));
        sb.push_back(mk(8'h04, 16'h0000, 2'd1, 12'd1, 1'b0));
        sb.push_back(mk(8'h60, 16'h0000, 2'd1, 12'd2, 1'b0));
        send(8'h03, 12'd0);
        send(8'h04, 12'd1);
        send(8'h60, 12'd2);
        idle(3);
        check("stream_count", pop_cyc.size(), 32'd3);
        if (pop_cyc.size() == 3) begin
            check("stream_gap01", pop_cyc[1] - pop_cyc[0], 32'd1);
            check("stream_gap12", pop_cyc[2] - pop_cyc[1], 32'd1);
        end

        // bipush -5 at pc 5, with one-cycle latency check
        sb.push_back(mk(8'h10, 16'h00FB, 2'd2, 12'd5, 1'b0));
        send(8'h10, 12'd5);
        send(8'hFB, 12'd6);
        in_valid = 1'b0;
        #1 check("bipush_latency", {31'd0, out_valid}, 32'd1);
        idle(2);

        // goto -3, iinc, newarray, iload
        sb.push_back(mk(8'ha7, 16'hFFFD, 2'd3, 12'd10, 1'b0));
        sb.push_back(mk(8'h84, 16'h0102, 2'd3, 12'd13, 1'b0));
        sb.push_back(mk(8'hbc, 16'h000A, 2'd2, 12'd16, 1'b0));
        sb.push_back(mk(8'h15, 16'h0003, 2'd2, 12'd18, 1'b0));
        send(8'ha7, 12'd10); send(8'hFF, 12'd11); send(8'hFD, 12'd12);
        send(8'h84, 12'd13); send(8'h01, 12'd14); send(8'h02, 12'd15);
        send(8'hbc, 12'd16); send(8'h0A, 12'd17);
        send(8'h15, 12'd18); send(8'h03, 12'd19);
        idle(3);

        // Consumer stall: outputs hold, in_ready low; release accepts next byte same cycle
        out_ready = 1'b0;
        sb.push_back(mk(8'h10, 16'h0007, 2'd2, 12'd20, 1'b0));
        send(8'h10, 12'd20);
        send(8'h07, 12'd21);
        in_valid = 1'b1;
        in_instr = 8'h00;
        in_pc    = 12'd22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_operand", {16'd0, out_operand}, 32'h0007);
            check("stall_pc", {20'd0, out_pc}, 32'd20);
            @(negedge clk);
        end
        sb.push_back(mk(8'h00, 16'h0000, 2'd1, 12'd22, 1'b0));
        out_ready = 1'b1;
        #1 check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        idle(3);

        // Flush mid-sipush drops the partial instruction and the byte presented with it
        send(8'h11, 12'd30);
        send(8'h12, 12'd31);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_instr = 8'h99;
        in_pc    = 12'd32;
        #1 check("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1 check("flush_no_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        sb.push_back(mk(8'h00, 16'h0000, 2'd1, 12'd40, 1'b0));
        send(8'h00, 12'd40);
        idle(3);

        // Illegal opcodes decode as single bytes
        sb.push_back(mk(8'haa, 16'h0000, 2'd1, 12'd50, 1'b1));
        sb.push_back(mk(8'hc8, 16'h0000, 2'd1, 12'd51, 1'b1));
        sb.push_back(mk(8'hff, 16'h0000, 2'd1, 12'd52, 1'b1));
        send(8'haa, 12'd50);
        send(8'hc8, 12'd51);
        send(8'hff, 12'd52);
        idle(3);

        // Reset mid-sipush: no emit, reset values next cycle
        send(8'h11, 12'd60);
        send(8'h22, 12'd61);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_opcode", {24'd0, out_opcode}, 32'h00);
        check("rst2_operand", {16'd0, out_operand}, 32'h0000);
        check("rst2_len", {30'd0, out_len}, 32'd1);
        check("rst2_pc", {20'd0, out_pc}, 32'h000);
        check("rst2_illegal", {31'd0, out_illegal}, 32'd0);
        @(negedge clk);
        sb.push_back(mk(8'h03, 16'h0000, 2'd1, 12'h070, 1'b0));
        send(8'h03, 12'h070);
        idle(1);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
